// File: rtl/eth_pkg.sv
// eth_pkg: shared Ethernet constants and the transmit FSM state type.
//   PREAMBLE_BYTE / SFD_BYTE : frame delimiters
//   CRC_POLY_REFL            : reflected CRC-32 polynomial
//   CRC_RESIDUE              : running-CRC value after a good body+FCS
//   tx_state_t               : frame generator states
package eth_pkg;
  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

  typedef enum logic [2:0] {
    ST_START_WAIT = 3'd0,
    ST_PREAMBLE   = 3'd1,
    ST_SFD        = 3'd2,
    ST_HEADER     = 3'd3,
    ST_PAYLOAD    = 3'd4,
    ST_FCS        = 3'd5,
    ST_IFG        = 3'd6
  } tx_state_t;
endpackage

// File: rtl/crc32_d8.sv
// crc32_d8: combinational byte-wide update of a reflected CRC-32.
//   crc_in  [31:0] : current CRC register
//   data    [7:0]  : byte being absorbed (LSB first on the wire)
//   crc_out [31:0] : CRC register after absorbing data
module crc32_d8
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);
  always_comb begin
    logic [31:0] c;
    c = crc_in ^ {24'h0, data};
    for (int i = 0; i < 8; i++)
      c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
    crc_out = c;
  end
endmodule

// File: rtl/gmii_to_rgmii.sv
// gmii_to_rgmii: periodic Ethernet II test-frame generator feeding an
// RGMII DDR transmitter, for PHY bring-up.
//   clk, rst            : 125 MHz clock, async active-high reset
//   rgmii_rx_*          : reserved, ignored
//   rgmii_tx_clk        : forwarded clk (held 0 in reset)
//   rgmii_tx_ctrl       : TX_EN (high phase) / TX_EN^TX_ER (low phase)
//   rgmii_txd[3:0]      : byte[3:0] in high phase, byte[7:4] in low phase
module gmii_to_rgmii
  import eth_pkg::*;
#(
  parameter logic [47:0] SRC_MAC     = 48'h02_00_00_00_00_01,
  parameter logic [47:0] DST_MAC     = 48'hFF_FF_FF_FF_FF_FF,
  parameter logic [15:0] ETHERTYPE   = 16'h88B5,
  parameter int          PAYLOAD_LEN = 46,
  parameter int          IFG_CYCLES  = 12,
  parameter int          START_DELAY = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rgmii_rx_clk,
  input  logic       rgmii_rx_ctrl,
  input  logic [3:0] rgmii_rxd,
  output logic       rgmii_tx_clk,
  output logic       rgmii_tx_ctrl,
  output logic [3:0] rgmii_txd
);
  localparam int MAX_A = (PAYLOAD_LEN > IFG_CYCLES) ? PAYLOAD_LEN : IFG_CYCLES;
  localparam int MAX_C = (MAX_A > START_DELAY) ? MAX_A : START_DELAY;
  localparam int CW    = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] LAST_START = CW'(START_DELAY - 1);
  localparam logic [CW-1:0] LAST_PRE   = CW'(6);
  localparam logic [CW-1:0] LAST_HDR   = CW'(13);
  localparam logic [CW-1:0] LAST_PAY   = CW'(PAYLOAD_LEN - 1);
  localparam logic [CW-1:0] LAST_FCS   = CW'(3);
  localparam logic [CW-1:0] LAST_IFG   = CW'(IFG_CYCLES - 1);

  localparam logic [111:0] HDR = {DST_MAC, SRC_MAC, ETHERTYPE};

  // RX side is reserved; fold it into a sink so it stays visibly unused.
  logic unused_rx;
  assign unused_rx = ^{rgmii_rx_clk, rgmii_rx_ctrl, rgmii_rxd};

  tx_state_t     state;
  logic [CW-1:0] cnt;
  logic [31:0]   crc, crc_next;
  logic [7:0]    byte_q;
  logic          en_q;

  logic [7:0]    gmii_d;
  logic          gmii_en;
  logic [CW-1:0] limit;
  logic [111:0]  hdr_sh;
  logic [31:0]   fcs_sh;

  assign hdr_sh = HDR << {cnt, 3'b000};
  // FCS goes out least-significant byte first.
  assign fcs_sh = (~crc) >> {cnt[1:0], 3'b000};

  always_comb begin
    gmii_d  = 8'h00;
    gmii_en = 1'b0;
    limit   = '0;
    case (state)
      ST_START_WAIT: limit = LAST_START;
      ST_PREAMBLE: begin gmii_d = PREAMBLE_BYTE; gmii_en = 1'b1; limit = LAST_PRE; end
      ST_SFD:      begin gmii_d = SFD_BYTE;      gmii_en = 1'b1; end
      ST_HEADER:   begin gmii_d = hdr_sh[111:104]; gmii_en = 1'b1; limit = LAST_HDR; end
      ST_PAYLOAD:  begin gmii_d = 8'(cnt);       gmii_en = 1'b1; limit = LAST_PAY; end
      ST_FCS:      begin gmii_d = fcs_sh[7:0];   gmii_en = 1'b1; limit = LAST_FCS; end
      ST_IFG:      limit = LAST_IFG;
      default:     limit = '0;
    endcase
  end

  // CRC absorbs the byte being loaded this cycle, so the register already
  // holds the final value when the FSM enters FCS.
  crc32_d8 u_crc (
    .crc_in (crc),
    .data   (gmii_d),
    .crc_out(crc_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_START_WAIT;
      cnt    <= '0;
      crc    <= '1;
      byte_q <= 8'h00;
      en_q   <= 1'b0;
    end else begin
      byte_q <= gmii_d;
      en_q   <= gmii_en;
      if (state == ST_SFD)
        crc <= '1;
      else if (state == ST_HEADER || state == ST_PAYLOAD)
        crc <= crc_next;
      if (cnt == limit) begin
        cnt <= '0;
        case (state)
          ST_START_WAIT: state <= ST_PREAMBLE;
          ST_PREAMBLE:   state <= ST_SFD;
          ST_SFD:        state <= ST_HEADER;
          ST_HEADER:     state <= ST_PAYLOAD;
          ST_PAYLOAD:    state <= ST_FCS;
          ST_FCS:        state <= ST_IFG;
          ST_IFG:        state <= ST_PREAMBLE;
          default:       state <= ST_START_WAIT;
        endcase
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // DDR mux on clk level. TX_ER is never asserted, so the low-phase
  // TX_EN^TX_ER reduces to TX_EN.
  assign rgmii_tx_clk  = clk & ~rst;
  assign rgmii_tx_ctrl = en_q;
  assign rgmii_txd     = clk ? byte_q[3:0] : byte_q[7:4];
endmodule

// File: tb/tb_gmii_to_rgmii.sv
// tb_gmii_to_rgmii: scoreboard bench. A frame reference built from the
// Ethernet rules predicts the pin byte for every cycle after reset release;
// a monitor rebuilds bytes from the DDR pins and checks them, plus per-frame
// length and CRC residue. Random mid-frame resets exercise the abort path.
module tb_gmii_to_rgmii;
  import eth_pkg::*;

  localparam int SD        = 16;
  localparam int PL        = 46;
  localparam int IFG       = 12;
  localparam int FRAME_LEN = 8 + 14 + PL + 4;
  localparam int PERIOD    = FRAME_LEN + IFG;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rgmii_rx_clk;
  logic       rgmii_rx_ctrl;
  logic [3:0] rgmii_rxd;
  logic       rgmii_tx_clk;
  logic       rgmii_tx_ctrl;
  logic [3:0] rgmii_txd;

  gmii_to_rgmii dut (
    .clk          (clk),
    .rst          (rst),
    .rgmii_rx_clk (rgmii_rx_clk),
    .rgmii_rx_ctrl(rgmii_rx_ctrl),
    .rgmii_rxd    (rgmii_rxd),
    .rgmii_tx_clk (rgmii_tx_clk),
    .rgmii_tx_ctrl(rgmii_tx_ctrl),
    .rgmii_txd    (rgmii_txd)
  );

  always #5 clk = ~clk;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] frame_ref [FRAME_LEN];
  logic [8:0] sb [$];
  logic [7:0] fr [$];

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] sw_crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++)
      r = (r >> 1) ^ (r[0] ? 32'hEDB88320 : 32'h0);
    return r;
  endfunction

  task automatic build_frame();
    logic [47:0] dst, src;
    logic [31:0] c;
    int p;
    dst = 48'hFF_FF_FF_FF_FF_FF;
    src = 48'h02_00_00_00_00_01;
    for (int i = 0; i < 7; i++) frame_ref[i] = 8'h55;
    frame_ref[7] = 8'hD5;
    for (int i = 0; i < 6; i++) frame_ref[8 + i]  = dst[47 - 8*i -: 8];
    for (int i = 0; i < 6; i++) frame_ref[14 + i] = src[47 - 8*i -: 8];
    frame_ref[20] = 8'h88;
    frame_ref[21] = 8'hB5;
    for (int i = 0; i < PL; i++) frame_ref[22 + i] = 8'(i);
    c = 32'hFFFF_FFFF;
    for (int i = 8; i < 22 + PL; i++) c = sw_crc_byte(c, frame_ref[i]);
    c = ~c;
    p = 22 + PL;
    for (int i = 0; i < 4; i++) frame_ref[p + i] = c[8*i +: 8];
  endtask

  // Expected {tx_en, byte} on the pins after the k-th rising edge since release.
  function automatic logic [8:0] exp_at(input int k);
    int j;
    if (k <= SD) return 9'h000;
    j = (k - SD - 1) % PERIOD;
    if (j < FRAME_LEN) return {1'b1, frame_ref[j]};
    return 9'h000;
  endfunction

  // Monitor: one reconstructed byte per clk, cycles touched by reset dropped.
  initial begin
    logic [3:0] lo, hi;
    logic ch, cl, kh, kl;
    logic [8:0] e;
    logic [31:0] c;
    forever begin
      @(posedge clk);
      if (rst) begin fr.delete(); continue; end
      #1;
      lo = rgmii_txd; ch = rgmii_tx_ctrl; kh = rgmii_tx_clk;
      @(negedge clk);
      #1;
      if (rst) begin fr.delete(); continue; end
      hi = rgmii_txd; cl = rgmii_tx_ctrl; kl = rgmii_tx_clk;
      if (sb.size() == 0) begin
        check("sb_underrun", 64'(sb.size()), 64'd1);
      end else begin
        e = sb.pop_front();
        check("cycle_clk_ctrl_byte", {52'h0, kh, kl, ch, cl, hi, lo},
              {52'h0, 1'b1, 1'b0, e[8], e[8], e[7:0]});
      end
      if (ch) begin
        fr.push_back({hi, lo});
      end else if (fr.size() > 0) begin
        check("frame_len", 64'(fr.size()), 64'(FRAME_LEN));
        c = 32'hFFFF_FFFF;
        for (int i = 8; i < fr.size(); i++) c = sw_crc_byte(c, fr[i]);
        check("fcs_residue", 64'(c), 64'(CRC_RESIDUE));
        fr.delete();
      end
    end
  end

  // Release at a falling edge, then run L rising edges with predictions queued.
  task automatic run_segment(input int L);
    rst = 1'b0;
    for (int k = 1; k <= L; k++) sb.push_back(exp_at(k));
    repeat (L) @(posedge clk);
  endtask

  task automatic mid_reset();
    int n;
    #3;
    rst = 1'b1;
    sb.delete();
    #1;
    check("async_reset_out", {61'h0, rgmii_tx_clk, rgmii_tx_ctrl, |rgmii_txd}, 64'h0);
    n = $urandom_range(2, 5);
    repeat (n) begin
      @(posedge clk);
      #2;
      check("reset_hold_out", {56'h0, rgmii_tx_clk, rgmii_tx_ctrl, 2'b0, rgmii_txd}, 64'h0);
    end
    @(negedge clk);
  endtask

  initial begin
    int L;
    rgmii_rx_clk  = 1'bz;
    rgmii_rx_ctrl = 1'bx;
    rgmii_rxd     = 4'bxxxx;
    build_frame();
    // Initial reset, probed in both clk phases.
    for (int t = 0; t < 4; t++) begin
      #(t == 0 ? 2 : 5);
      check("reset_out", {56'h0, rgmii_tx_clk, rgmii_tx_ctrl, 2'b0, rgmii_txd}, 64'h0);
    end
    @(negedge clk);
    // Long run: several frames, covering periodicity.
    run_segment(500);
    mid_reset();
    // Random mid-payload aborts, in the first or second frame.
    for (int r = 0; r < 3; r++) begin
      L = SD + 1 + 22 + PERIOD * $urandom_range(0, 1) + $urandom_range(0, PL - 1);
      run_segment(L);
      mid_reset();
    end
    // Clean recovery after the last abort.
    run_segment(300);
    @(negedge clk);
    #2;
    check("sb_drain", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
